// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS-subset control path.
// Opcodes, ALU codes, state encoding and mux select codes.
package mc_pkg;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  localparam logic [1:0] PC_ALU   = 2'b00;
  localparam logic [1:0] PC_ALUO  = 2'b01;
  localparam logic [1:0] PC_JUMP  = 2'b10;
  localparam logic [1:0] PC_RS    = 2'b11;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JR       = 4'd12
  } state_t;

  typedef struct packed {
    logic r_alu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic jr;
    logic illegal;
  } class_t;

endpackage

// File: rtl/mc_instr_class.sv
// One-hot instruction class decode from the IR contents.
// Anything not recognised lands in the illegal class.
module mc_instr_class
  import mc_pkg::*;
(
  input  logic [31:0] instr,
  output class_t      cls
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       rtype;

  assign op    = instr[31:26];
  assign fn    = instr[5:0];
  assign rtype = (op == OP_R);

  always_comb begin
    cls       = '0;
    cls.r_alu = rtype && (fn == FN_ADD || fn == FN_SUB);
    cls.jr    = rtype && (fn == FN_JR);
    cls.ori   = (op == OP_ORI);
    cls.lui   = (op == OP_LUI);
    cls.lw    = (op == OP_LW);
    cls.sw    = (op == OP_SW);
    cls.beq   = (op == OP_BEQ);
    cls.jal   = (op == OP_JAL);
    cls.illegal = ~(cls.r_alu | cls.jr | cls.ori | cls.lui |
                    cls.lw | cls.sw | cls.beq | cls.jal);
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback.
// Moore outputs per state; the opcode only picks variants.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic [2:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_op,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        instr_done
);

  state_t state;
  state_t state_nx;
  class_t cls;

  mc_instr_class u_cls (
    .instr (instr),
    .cls   (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= state_t'(RESET_STATE);
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    alu_op     = ALU_AND;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    ext_op     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = WB_ALU;
    instr_done = 1'b0;
    // Reset masks every enable so an aborted instruction writes nothing.
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
          state_nx  = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM4;
          ext_op    = 1'b1;
          alu_op    = ALU_ADD;
          unique case (1'b1)
            cls.r_alu:      state_nx = S_EXEC_R;
            cls.ori,
            cls.lui:        state_nx = S_EXEC_I;
            cls.lw, cls.sw: state_nx = S_MEM_ADDR;
            cls.beq:        state_nx = S_BRANCH;
            cls.jal:        state_nx = S_JAL;
            cls.jr:         state_nx = S_JR;
            default: begin
              instr_done = 1'b1;
              state_nx   = S_FETCH;
            end
          endcase
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = (instr[5:0] == FN_SUB) ? ALU_SUB : ALU_ADD;
          state_nx  = S_WB_R;
        end
        S_WB_R: begin
          reg_write  = 1'b1;
          reg_dst    = DST_RD;
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end
        S_EXEC_I: begin
          alu_src_b = SRCB_IMM;
          alu_src_a = cls.ori;
          alu_op    = cls.ori ? ALU_OR : ALU_LUI;
          state_nx  = S_WB_I;
        end
        S_WB_I: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          ext_op    = 1'b1;
          alu_op    = ALU_ADD;
          state_nx  = cls.sw ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: state_nx = S_MEM_WB;
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = WB_MDR;
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_src     = PC_ALUO;
          pc_write   = zero;
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          pc_src     = PC_JUMP;
          reg_write  = 1'b1;
          reg_dst    = DST_RA;
          mem_to_reg = WB_PC;
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end
        S_JR: begin
          pc_write   = 1'b1;
          pc_src     = PC_RS;
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end
        default: state_nx = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-cycle expected control words
// are queued per instruction and compared cycle by cycle.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       ext;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       mw;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] m2r;
    logic       done;
  } ctl_t;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic [2:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        ext_op;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        instr_done;

  int checks;
  int failures;
  ctl_t sb[$];
  ctl_t got;

  mc_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .zero       (zero),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_op     (ext_op),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = '{alu_op, alu_src_a, alu_src_b, ext_op,
                 ir_write, pc_write, pc_src, mem_write,
                 reg_write, reg_dst, mem_to_reg, instr_done};

  localparam ctl_t C_IDLE = '0;
  localparam ctl_t C_FETCH =
    '{alu_op:3'b010, src_b:2'b01, irw:1'b1, pcw:1'b1, default:'0};
  localparam ctl_t C_DEC =
    '{alu_op:3'b010, src_b:2'b11, ext:1'b1, default:'0};
  localparam ctl_t C_DEC_BAD =
    '{alu_op:3'b010, src_b:2'b11, ext:1'b1, done:1'b1, default:'0};
  localparam ctl_t C_ADD =
    '{alu_op:3'b010, src_a:1'b1, default:'0};
  localparam ctl_t C_SUB =
    '{alu_op:3'b011, src_a:1'b1, default:'0};
  localparam ctl_t C_WBR =
    '{rw:1'b1, rd:2'b01, done:1'b1, default:'0};
  localparam ctl_t C_ORI =
    '{alu_op:3'b001, src_a:1'b1, src_b:2'b10, default:'0};
  localparam ctl_t C_LUI =
    '{alu_op:3'b100, src_b:2'b10, default:'0};
  localparam ctl_t C_WBI =
    '{rw:1'b1, done:1'b1, default:'0};
  localparam ctl_t C_MADDR =
    '{alu_op:3'b010, src_a:1'b1, src_b:2'b10, ext:1'b1, default:'0};
  localparam ctl_t C_MWB =
    '{rw:1'b1, m2r:2'b01, done:1'b1, default:'0};
  localparam ctl_t C_MWR =
    '{mw:1'b1, done:1'b1, default:'0};
  localparam ctl_t C_BEQ1 =
    '{alu_op:3'b011, src_a:1'b1, pcs:2'b01, pcw:1'b1,
      done:1'b1, default:'0};
  localparam ctl_t C_BEQ0 =
    '{alu_op:3'b011, src_a:1'b1, pcs:2'b01, done:1'b1, default:'0};
  localparam ctl_t C_JAL =
    '{pcw:1'b1, pcs:2'b10, rw:1'b1, rd:2'b10, m2r:2'b10,
      done:1'b1, default:'0};
  localparam ctl_t C_JR =
    '{pcw:1'b1, pcs:2'b11, done:1'b1, default:'0};

  task automatic chk(input string tag, input ctl_t obs, input ctl_t exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%05h exp=%05h", tag, obs, exp);
    end
  endtask

  // Drains the scoreboard, one control word per cycle, starting at S_FETCH.
  task automatic run(input string tag, input logic [31:0] i, input logic z);
    int cyc;
    cyc = 1;
    while (sb.size() != 0) begin
      instr = i;
      zero  = z;
      #1;
      chk($sformatf("%s_c%0d", tag, cyc), got, sb.pop_front());
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic push3(input ctl_t a, input ctl_t b, input ctl_t c);
    sb.push_back(a);
    sb.push_back(b);
    sb.push_back(c);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    instr    = 32'h0;
    zero     = 1'b0;
    @(negedge clk);
    chk("rst_c1", got, C_IDLE);
    @(negedge clk);
    chk("rst_c2", got, C_IDLE);
    reset = 1'b0;

    push3(C_FETCH, C_DEC, C_ADD); sb.push_back(C_WBR);
    run("add", 32'h00221820, 1'b0);
    push3(C_FETCH, C_DEC, C_SUB); sb.push_back(C_WBR);
    run("sub", 32'h00221822, 1'b0);
    push3(C_FETCH, C_DEC, C_ORI); sb.push_back(C_WBI);
    run("ori", 32'h34220005, 1'b0);
    push3(C_FETCH, C_DEC, C_LUI); sb.push_back(C_WBI);
    run("lui", 32'h3C020005, 1'b0);
    push3(C_FETCH, C_DEC, C_MADDR);
    sb.push_back(C_IDLE); sb.push_back(C_MWB);
    run("lw", 32'h8C230004, 1'b0);
    push3(C_FETCH, C_DEC, C_MADDR); sb.push_back(C_MWR);
    run("sw", 32'hAC230004, 1'b0);
    push3(C_FETCH, C_DEC, C_BEQ1);
    run("beq_z1", 32'h10220003, 1'b1);
    push3(C_FETCH, C_DEC, C_BEQ0);
    run("beq_z0", 32'h10220003, 1'b0);
    push3(C_FETCH, C_DEC, C_JAL);
    run("jal", 32'h0C000010, 1'b0);
    push3(C_FETCH, C_DEC, C_JR);
    run("jr", 32'h03E00008, 1'b0);
    sb.push_back(C_FETCH); sb.push_back(C_DEC_BAD);
    run("bad_op", 32'hFC000000, 1'b0);
    sb.push_back(C_FETCH); sb.push_back(C_DEC_BAD);
    run("bad_fn", 32'h00221821, 1'b0);

    // Abort lw in S_MEM_RD: no writeback, restart at fetch.
    push3(C_FETCH, C_DEC, C_MADDR);
    run("lw_ab", 32'h8C230004, 1'b0);
    reset = 1'b1;
    #1;
    chk("abort_rd", got, C_IDLE);
    @(negedge clk);
    chk("abort_hold", got, C_IDLE);
    reset = 1'b0;
    sb.push_back(C_FETCH); sb.push_back(C_DEC);
    run("post_ab", 32'h8C230004, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle control unit for the MIPS-subset datapath. It is the producer side of the ALU interface: it drives the 3-bit ALU opcode and mux selects, and it consumes the ALU's combinational zero flag for beq. It sequences each instruction through fetch, decode, execute, memory and writeback states. It sits between the IR, PC, register file, data memory and ALU; the datapath registers (IR, MDR, A, B, ALUOut) live outside this block.

Parameters:
RESET_STATE, 4'd0 (S_FETCH), state entered on reset.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high.
instr  in  32  current IR contents; stable from the cycle after S_FETCH.
zero  in  1  ALU equality flag, combinational A==B.
alu_op  out  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 LUI (B<<16).
alu_src_a  out  1  0 = PC, 1 = rs register.
alu_src_b  out  2  00 rt, 01 constant 4, 10 extended imm, 11 extended imm<<2.
ext_op  out  1  0 = zero-extend, 1 = sign-extend.
ir_write  out  1  load IR from instruction memory.
pc_write  out  1  PC write enable (branch qualification is already applied).
pc_src  out  2  00 ALU result, 01 ALUOut, 10 {PC[31:28],instr[25:0],2'b00}, 11 rs.
mem_write  out  1  data memory write strobe.
reg_write  out  1  register file write enable.
reg_dst  out  2  00 rt, 01 rd, 10 $31.
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC.
instr_done  out  1  one-cycle pulse in the final state of each instruction.

Behaviour:
- Reset: synchronous, active-high.
  - state <= S_FETCH.
  - While reset is high, every enable (ir_write, pc_write, mem_write, reg_write, instr_done) is forced 0 and all selects are 0.
  - Reset asserted mid-instruction aborts it; nothing is written in that cycle.
- State register is clocked. Outputs decode combinationally from state plus instr opcode/funct (Moore per state; opcode only selects variants).
- Supported instructions: add/sub/jr (op 000000, funct 100000/100010/001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, jal 000011.
- States and their asserted outputs:
  - S_FETCH: ir_write, pc_write, src_a=0, src_b=01, ADD, pc_src=00. Next state S_DECODE.
  - S_DECODE: src_a=0, src_b=11, ext_op=1, ADD (branch target into ALUOut). Next state by class: R-ALU→S_EXEC_R; ori/lui→S_EXEC_I; lw/sw→S_MEM_ADDR; beq→S_BRANCH; jal→S_JAL; jr→S_JR. Unknown opcode or funct→S_FETCH with instr_done=1 (executes as a nop).
  - S_EXEC_R: src_a=1, src_b=00, ADD or SUB by funct. Next S_WB_R.
  - S_WB_R: reg_write, reg_dst=01, mem_to_reg=00, instr_done. Next S_FETCH.
  - S_EXEC_I: src_b=10, ext_op=0. ori uses src_a=1 and OR; lui uses 100. Next S_WB_I.
  - S_WB_I: reg_write, reg_dst=00, mem_to_reg=00, instr_done. Next S_FETCH.
  - S_MEM_ADDR: src_a=1, src_b=10, ext_op=1, ADD. lw→S_MEM_RD, sw→S_MEM_WR.
  - S_MEM_RD: read cycle; MDR latches externally. Next S_MEM_WB.
  - S_MEM_WB: reg_write, reg_dst=00, mem_to_reg=01, instr_done. Next S_FETCH.
  - S_MEM_WR: mem_write, instr_done. Next S_FETCH.
  - S_BRANCH: src_a=1, src_b=00, SUB, pc_src=01, pc_write=zero, instr_done. Next S_FETCH.
  - S_JAL: pc_write, pc_src=10, reg_write, reg_dst=10, mem_to_reg=10 (PC already holds PC+4), instr_done. Next S_FETCH.
  - S_JR: pc_write, pc_src=11, instr_done. Next S_FETCH.
- Latency in cycles: beq/jal/jr 3; R-type, ori, lui, sw 4; lw 5.
- Only one write enable among mem_write/reg_write is active per cycle, except S_JAL (reg_write plus pc_write).
- Outputs in states where a field is not listed default to 0.

Decomposition:
- Package mc_pkg holds:
  - opcode and funct constants;
  - ALU_AND/OR/ADD/SUB/LUI codes, shared with the ALU;
  - 4-bit state encoding;
  - select-code constants for pc_src, alu_src_b, reg_dst, mem_to_reg.
- One sub-module, mc_instr_class: combinational decode of instr into a one-hot class (r_alu, ori, lui, lw, sw, beq, jal, jr, illegal).

Test Plan:
- Reset held 2 cycles, then released → first cycle S_FETCH with ir_write=1, pc_write=1, alu_op=010; all enables were 0 during reset.
- add $3,$1,$2 (0x00221820) → 4 cycles; S_EXEC_R alu_op=010; reg_write=1 with reg_dst=01 and instr_done=1 in cycle 4.
- lw then sw (0x8C230004, 0xAC230004) → lw: 5 cycles, mem_to_reg=01 in cycle 5. sw: 4 cycles, mem_write=1 only in cycle 4, reg_write never asserted.
- beq (0x10220003), run twice: zero=1 → pc_write=1 and pc_src=01 in cycle 3; zero=0 → pc_write=0 in cycle 3. instr_done=1 in both runs.
- jal 0x0C000010 → cycle 3: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10. Follow with jr $31 (0x03E00008) → cycle 3: pc_src=11.
- Two more cases:
  - Opcode 0x3F → S_DECODE returns to S_FETCH with instr_done=1 and no writes.
  - Reset asserted during S_MEM_RD → next cycle S_FETCH, reg_write never pulses.
